odelay_tap_model: RTL and testbench

ODELAY_TAP_MODEL -- requirements
Module: odelay_tap_model

---
 rtl/odelay_pkg.sv | 18 +
 rtl/sat_cnt8.sv | 22 ++
 rtl/odelay_tap_model.sv | 165 ++++++++++++++++
 tb/tb_odelay_tap_model.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odelay_pkg.sv
// Shared types and defaults for the output-delay tap model.
// State encoding plus parameter defaults used by the top.
package odelay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SETTLE
  } state_t;

  localparam int TAP_W_D      = 9;
  localparam int MAX_STEP_D   = 8;
  localparam int MAX_TAP_D    = 511;
  localparam int LOAD_LAT_D   = 2;
  localparam int SETTLE_CYC_D = 4;
  localparam int INIT_TAP_D   = 0;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter.
// Clear and increment together leave the counter at one.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  // count events, stick at 255, clear has lower priority than a new event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= {7'd0, inc};
    end else if (inc && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/odelay_tap_model.sv
// Behavioural output-delay tap controller.
// Loads are step/range clamped, applied after a latency, then settle.
module odelay_tap_model
  import odelay_pkg::*;
#(
  parameter int TAP_W      = TAP_W_D,
  parameter int MAX_STEP   = MAX_STEP_D,
  parameter int MAX_TAP    = MAX_TAP_D,
  parameter int LOAD_LAT   = LOAD_LAT_D,
  parameter int SETTLE_CYC = SETTLE_CYC_D,
  parameter int INIT_TAP   = INIT_TAP_D
) (
  input  logic             clk160,
  input  logic             rstb,
  input  logic [TAP_W-1:0] delay_set_value,
  input  logic             delay_wr,
  input  logic             err_clr,
  output logic [TAP_W-1:0] delay_out,
  output logic             busy,
  output logic             step_err,
  output logic             range_err,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       step_err_cnt
);

  localparam logic signed [TAP_W:0] STEP_S =
    (TAP_W+1)'(MAX_STEP);
  localparam logic [TAP_W:0] STEP_U =
    (TAP_W+1)'(MAX_STEP);
  localparam logic [TAP_W:0] TAP_LIM =
    (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_RST =
    TAP_W'(INIT_TAP);
  localparam logic [3:0] LAT_M1 =
    4'(LOAD_LAT - 1);
  localparam logic [3:0] SET_M1 =
    4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t state;
  state_t state_nx;

  logic [3:0]       cnt;
  logic [3:0]       cnt_nx;
  logic [TAP_W-1:0] pend_val;
  logic [TAP_W-1:0] pend_nx;
  logic [TAP_W-1:0] out_nx;
  logic             accept;
  logic             drop;
  logic             se;
  logic             re;

  logic signed [TAP_W:0] diff;
  logic [TAP_W:0]        clamp;
  logic [TAP_W:0]        appl;

  // step clamp first, then range clamp of the stepped value
  always_comb begin
    se    = 1'b0;
    diff  = $signed({1'b0, delay_set_value})
          - $signed({1'b0, delay_out});
    clamp = {1'b0, delay_set_value};
    if (diff > STEP_S) begin
      clamp = {1'b0, delay_out} + STEP_U;
      se    = 1'b1;
    end else if (diff < -STEP_S) begin
      clamp = {1'b0, delay_out} - STEP_U;
      se    = 1'b1;
    end
    re   = (clamp > TAP_LIM);
    appl = re ? TAP_LIM : clamp;
  end

  // load / latency / settle sequencing
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend_val;
    out_nx   = delay_out;
    accept   = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (delay_wr) begin
          accept   = 1'b1;
          pend_nx  = appl[TAP_W-1:0];
          cnt_nx   = LAT_M1;
          state_nx = PEND;
        end
      end
      PEND: begin
        drop = delay_wr;
        if (cnt == 4'd0) begin
          out_nx = pend_val;
          if (SETTLE_CYC == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = SETTLE;
            cnt_nx   = SET_M1;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      SETTLE: begin
        drop = delay_wr;
        if (cnt == 4'd0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state, tap and busy registers
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend_val  <= TAP_RST;
      delay_out <= TAP_RST;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_val  <= pend_nx;
      delay_out <= out_nx;
      busy      <= (state_nx != IDLE);
    end
  end

  // sticky flags; a fresh error beats a simultaneous clear
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      step_err  <= 1'b0;
      range_err <= 1'b0;
    end else if (err_clr) begin
      step_err  <= accept & se;
      range_err <= accept & re;
    end else begin
      step_err  <= step_err | (accept & se);
      range_err <= range_err | (accept & re);
    end
  end

  sat_cnt8 u_drop_cnt (
    .clk   (clk160),
    .rst_n (rstb),
    .clr   (err_clr),
    .inc   (drop),
    .cnt   (drop_cnt)
  );

  sat_cnt8 u_step_cnt (
    .clk   (clk160),
    .rst_n (rstb),
    .clr   (err_clr),
    .inc   (accept & se),
    .cnt   (step_err_cnt)
  );

endmodule

// File: tb/tb_odelay_tap_model.sv
// Scoreboard bench for odelay_tap_model.
// Expected state per edge is queued; a monitor compares after each edge.
module tb_odelay_tap_model;

  localparam int TW  = 9;
  localparam int MS  = 8;
  localparam int MT  = 509;
  localparam int LAT = 2;
  localparam int SC  = 4;
  localparam int IT  = 0;

  logic          clk160 = 1'b0;
  logic          rstb = 1'b0;
  logic [TW-1:0] delay_set_value = '0;
  logic          delay_wr = 1'b0;
  logic          err_clr = 1'b0;
  logic [TW-1:0] delay_out;
  logic          busy;
  logic          step_err;
  logic          range_err;
  logic [7:0]    drop_cnt;
  logic [7:0]    step_err_cnt;

  odelay_tap_model #(
    .TAP_W      (TW),
    .MAX_STEP   (MS),
    .MAX_TAP    (MT),
    .LOAD_LAT   (LAT),
    .SETTLE_CYC (SC),
    .INIT_TAP   (IT)
  ) dut (
    .clk160          (clk160),
    .rstb            (rstb),
    .delay_set_value (delay_set_value),
    .delay_wr        (delay_wr),
    .err_clr         (err_clr),
    .delay_out       (delay_out),
    .busy            (busy),
    .step_err        (step_err),
    .range_err       (range_err),
    .drop_cnt        (drop_cnt),
    .step_err_cnt    (step_err_cnt)
  );

  always #5 clk160 = ~clk160;

  typedef struct {
    int out;
    bit bsy;
    bit serr;
    bit rerr;
    int drop;
    int scnt;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nbad = 0;

  // reference model: event times instead of state encoding
  int m_out = IT;
  int m_pv = 0;
  int upd_e = 0;
  int idle_e = 0;
  int e_n = 0;
  bit m_pend = 0;
  bit m_busy = 0;
  bit m_se = 0;
  bit m_re = 0;
  int m_drop = 0;
  int m_scnt = 0;
  bit rst_req = 1;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_edge(input bit wr, input int val, input bit clr);
    bit acc;
    bit drp;
    bit se;
    bit re;
    int d;
    int a;
    exp_t x;
    e_n++;
    if (!rstb) begin
      m_out = IT; m_pend = 0; m_busy = 0;
      m_se = 0; m_re = 0; m_drop = 0; m_scnt = 0;
    end else begin
      acc = wr && !m_busy;
      drp = wr && m_busy;
      se = 0;
      re = 0;
      if (acc) begin
        d = val - m_out;
        a = val;
        if (d > MS) begin
          a = m_out + MS; se = 1;
        end else if (d < -MS) begin
          a = m_out - MS; se = 1;
        end
        if (a > MT) begin
          a = MT; re = 1;
        end
        m_pv = a;
        m_pend = 1;
        upd_e = e_n + LAT;
        idle_e = e_n + LAT + SC;
      end
      if (clr) begin
        m_se = se; m_re = re;
        m_scnt = int'(se); m_drop = int'(drp);
      end else begin
        m_se = m_se | se; m_re = m_re | re;
        m_scnt = sat(m_scnt + int'(se));
        m_drop = sat(m_drop + int'(drp));
      end
      if (m_pend && e_n == upd_e) m_out = m_pv;
      m_busy = m_pend && (e_n < idle_e);
      if (m_pend && e_n >= idle_e) m_pend = 0;
    end
    x.out = m_out; x.bsy = m_busy;
    x.serr = m_se; x.rerr = m_re;
    x.drop = m_drop; x.scnt = m_scnt;
    q.push_back(x);
  endtask

  task automatic cyc(input bit wr, input int val, input bit clr);
    @(negedge clk160);
    if (rst_req && rstb) begin
      rstb = 1'b0;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_out", int'(delay_out), IT);
    end else begin
      rstb = !rst_req;
    end
    delay_wr = wr;
    delay_set_value = val[TW-1:0];
    err_clr = clr;
    model_edge(wr, val, clr);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_busy && g < 64) begin
      cyc(0, 0, 0);
      g++;
    end
  endtask

  task automatic load(input int v);
    cyc(1, v, 0);
    wait_idle();
  endtask

  // monitor: one queued expectation per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk160);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("delay_out", int'(delay_out), x.out);
        chk("busy", int'(busy), int'(x.bsy));
        chk("step_err", int'(step_err), int'(x.serr));
        chk("range_err", int'(range_err), int'(x.rerr));
        chk("drop_cnt", int'(drop_cnt), x.drop);
        chk("step_err_cnt", int'(step_err_cnt), x.scnt);
      end
    end
  end

  initial begin
    int v;
    int g;
    bit wr;
    bit clr;
    rst_req = 1;
    repeat (3) cyc(0, 0, 0);
    rst_req = 0;
    repeat (6) cyc(0, 0, 0);
    load(5);
    repeat (3) cyc(0, 0, 0);
    while (m_out < 100) load((m_out + 8 > 100) ? 100 : m_out + 8);
    load(120);
    load(90);
    cyc(1, 200, 1);
    wait_idle();
    cyc(1, m_out, 0);
    repeat (3) cyc(1, 7, 0);
    wait_idle();
    repeat (2) cyc(0, 0, 0);
    repeat (380) cyc(1, m_out, 0);
    wait_idle();
    while (m_out < 508) load((m_out + 8 > 508) ? 508 : m_out + 8);
    load(511);
    repeat (2) cyc(0, 0, 0);
    cyc(1, 505, 0);
    rst_req = 1;
    repeat (2) cyc(0, 0, 0);
    rst_req = 0;
    repeat (10) cyc(0, 0, 0);
    repeat (3000) begin
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        v = int'($urandom_range(0, 511));
      end else begin
        v = m_out + int'($urandom_range(0, 40)) - 20;
        if (v < 0) v = 0;
        if (v > 511) v = 511;
      end
      clr = ($urandom_range(0, 29) == 0);
      rst_req = ($urandom_range(0, 399) == 0);
      cyc(wr, v, clr);
    end
    rst_req = 0;
    repeat (12) cyc(0, 0, 0);
    g = 0;
    while (q.size() > 0 && g < 20) begin
      @(posedge clk160);
      g++;
    end
    #2;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
